// File: rtl/heroe_pkg.sv
// heroe_pkg: shared codes between the obstacle generator and the collision detector
package heroe_pkg;

    typedef enum logic [2:0] {
        PR_OFF    = 3'd0,
        PR_INICIO = 3'd1,
        PR_MENU   = 3'd2,
        PR_GAME   = 3'd3,
        PR_WL     = 3'd4,
        PR_PA     = 3'd5
    } presente_t;

    typedef enum logic [1:0] {
        RES_JUEGO  = 2'b00,
        RES_PIERDE = 2'b01,
        RES_GANA   = 2'b10
    } resultado_t;

    typedef enum logic [1:0] {
        PIE      = 2'b00,
        SALTO    = 2'b01,
        AGACHADO = 2'b10
    } postura_t;

    localparam logic [4:0] TIPO_BONO = 5'd16;

endpackage

// File: rtl/postura_heroe.sv
// postura_heroe: hero posture FSM with the airborne tick counter
module postura_heroe
    import heroe_pkg::*;
#(
    parameter int SALTO_TICKS = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr,
    input  logic     freeze,
    input  logic     tick,
    input  logic     btn_salto,
    input  logic     btn_agachar,
    output postura_t postura
);

    postura_t   est_n;
    logic [2:0] cnt, cnt_n;

    // State register: clear forces PIE, a decided game freezes the posture
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            postura <= PIE;
            cnt     <= 3'd0;
        end else if (!freeze) begin
            postura <= est_n;
            cnt     <= cnt_n;
        end
    end

    // Next state: jump beats crouch, airborne ignores buttons until the counter runs out
    always_comb begin
        est_n = postura;
        cnt_n = cnt;
        case (postura)
            PIE: begin
                if (btn_salto) begin
                    est_n = SALTO;
                    cnt_n = 3'(SALTO_TICKS);
                end else if (btn_agachar) begin
                    est_n = AGACHADO;
                end
            end
            SALTO: begin
                if (tick) begin
                    est_n = cnt > 3'd1 ? SALTO : PIE;
                    cnt_n = cnt > 3'd1 ? cnt - 3'd1 : 3'd0;
                end
            end
            AGACHADO: est_n = btn_agachar ? AGACHADO : PIE;
            default:  est_n = PIE;
        endcase
    end

endmodule

// File: rtl/detector_colisiones.sv
// detector_colisiones: rebuilds obstacle types per slot and judges each arrival at the hero
module detector_colisiones
    import heroe_pkg::*;
#(
    parameter logic [2:0] GAME        = 3'd3,
    parameter logic [2:0] WL          = 3'd4,
    parameter int         VIDAS       = 3,
    parameter int         SALTO_TICKS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  presente,
    input  logic        clk_obstaculos,
    input  logic [4:0]  tipo_obs,
    input  logic [20:0] display_obs,
    input  logic [1:0]  mundo,
    input  logic        btn_salto,
    input  logic        btn_agachar,
    output logic        bono_tomado,
    output logic [1:0]  W_or_L,
    output logic [1:0]  vidas,
    output logic        golpe,
    output logic [1:0]  postura
);

    logic       clk_q, tick, activo, adv, hit;
    logic [4:0] slot0, slot1, slot2;
    postura_t   post;
    logic       unused_bits;

    // slot1 is the value slot0 takes on this tick; only the entry segments matter
    assign tick        = clk_obstaculos & ~clk_q;
    assign activo      = presente == GAME || presente == WL;
    assign adv         = tick && presente == GAME && W_or_L == RES_JUEGO;
    assign hit         = slot1 != 5'd0 && slot1 != TIPO_BONO && (slot1[0] ? post != SALTO : post != AGACHADO);
    assign postura     = post;
    assign unused_bits = ^{display_obs[13:0], slot0};

    // Tick edge, type pipeline, lives and result; leaving GAME/WL restores the reset state
    always_ff @(posedge clk) begin
        if (!rst_n || !activo) begin
            clk_q       <= 1'b0;
            slot0       <= 5'd0;
            slot1       <= 5'd0;
            slot2       <= 5'd0;
            bono_tomado <= 1'b0;
            golpe       <= 1'b0;
            W_or_L      <= RES_JUEGO;
            vidas       <= 2'(VIDAS);
        end else begin
            clk_q       <= clk_obstaculos;
            bono_tomado <= adv && slot1 == TIPO_BONO;
            golpe       <= adv && hit && vidas > 2'd1;
            if (adv) begin
                slot0 <= slot1;
                slot1 <= slot2;
                slot2 <= tipo_obs == TIPO_BONO ? TIPO_BONO : (display_obs[20:14] != 7'd0 ? tipo_obs : 5'd0);
                if (slot1 == TIPO_BONO && mundo == 2'd2)
                    W_or_L <= RES_GANA;
                if (hit) begin
                    vidas <= vidas - 2'd1;
                    if (vidas <= 2'd1)
                        W_or_L <= RES_PIERDE;
                end
            end
        end
    end

    postura_heroe #(
        .SALTO_TICKS (SALTO_TICKS)
    ) u_postura (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (!activo),
        .freeze      (W_or_L != RES_JUEGO),
        .tick        (tick),
        .btn_salto   (btn_salto),
        .btn_agachar (btn_agachar),
        .postura     (post)
    );

endmodule

// File: tb/tb_detector_colisiones.sv
// tb_detector_colisiones: directed scoreboard bench for the collision detector
module tb_detector_colisiones;
    import heroe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  presente = 3'd3;
    logic        clk_obstaculos = 1'b0;
    logic [4:0]  tipo_obs = 5'd0;
    logic [20:0] display_obs = 21'd0;
    logic [1:0]  mundo = 2'd0;
    logic        btn_salto = 1'b0;
    logic        btn_agachar = 1'b0;
    logic        bono_tomado, golpe;
    logic [1:0]  W_or_L, vidas, postura;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        string      tag;
        logic       bono;
        logic       golpe;
        logic [1:0] wl;
        logic [1:0] vid;
        logic [1:0] post;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    detector_colisiones dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .presente       (presente),
        .clk_obstaculos (clk_obstaculos),
        .tipo_obs       (tipo_obs),
        .display_obs    (display_obs),
        .mundo          (mundo),
        .btn_salto      (btn_salto),
        .btn_agachar    (btn_agachar),
        .bono_tomado    (bono_tomado),
        .W_or_L         (W_or_L),
        .vidas          (vidas),
        .golpe          (golpe),
        .postura        (postura)
    );

    task automatic cmp(input string tag, input logic [1:0] got, input logic [1:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic push(input string tag, input logic b, input logic g,
                        input logic [1:0] w, input logic [1:0] v, input logic [1:0] p);
        exp_t e;
        e.tag = tag; e.bono = b; e.golpe = g; e.wl = w; e.vid = v; e.post = p;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        cmp({e.tag, ".bono"},    {1'b0, bono_tomado}, {1'b0, e.bono});
        cmp({e.tag, ".golpe"},   {1'b0, golpe},       {1'b0, e.golpe});
        cmp({e.tag, ".W_or_L"},  W_or_L,              e.wl);
        cmp({e.tag, ".vidas"},   vidas,               e.vid);
        cmp({e.tag, ".postura"}, postura,             e.post);
    endtask

    // One clk with no obstacle step, then compare
    task automatic idle(input string tag, input logic b, input logic g,
                        input logic [1:0] w, input logic [1:0] v, input logic [1:0] p);
        push(tag, b, g, w, v, p);
        @(negedge clk);
        pop_check();
    endtask

    // Generator step: clk_obstaculos high for one clk; the detector acts on the following edge
    task automatic step(input logic [4:0] t, input logic [6:0] seg, input string tag,
                        input logic b, input logic g, input logic [1:0] w,
                        input logic [1:0] v, input logic [1:0] p);
        push(tag, b, g, w, v, p);
        @(negedge clk);
        btn_salto      = 1'b0;
        clk_obstaculos = 1'b1;
        tipo_obs       = t;
        display_obs    = {seg, 14'h2AAA};
        @(negedge clk);
        clk_obstaculos = 1'b0;
        tipo_obs       = 5'd0;
        display_obs    = 21'd0;
        pop_check();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle("rst", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);

        step(5'd5, 7'h7F, "lo_in",   1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);
        step(5'd3, 7'h00, "lo_mask", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);
        btn_salto = 1'b1;
        step(5'd0, 7'h00, "lo_jump",   1'b0, 1'b0, RES_JUEGO, 2'd3, SALTO);
        step(5'd0, 7'h00, "jump_land", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);

        step(5'd5, 7'h01, "lo2_in",  1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);
        step(5'd0, 7'h00, "lo2_mid", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);
        step(5'd0, 7'h00, "lo2_hit", 1'b0, 1'b1, RES_JUEGO, 2'd2, PIE);
        idle("lo2_after", 1'b0, 1'b0, RES_JUEGO, 2'd2, PIE);

        step(5'd6, 7'h40, "hi_in",  1'b0, 1'b0, RES_JUEGO, 2'd2, PIE);
        step(5'd0, 7'h00, "hi_mid", 1'b0, 1'b0, RES_JUEGO, 2'd2, PIE);
        step(5'd0, 7'h00, "hi_hit", 1'b0, 1'b1, RES_JUEGO, 2'd1, PIE);
        idle("hi_after", 1'b0, 1'b0, RES_JUEGO, 2'd1, PIE);

        btn_agachar = 1'b1;
        idle("crouch", 1'b0, 1'b0, RES_JUEGO, 2'd1, AGACHADO);
        step(5'd6, 7'h7F, "duck_in",  1'b0, 1'b0, RES_JUEGO, 2'd1, AGACHADO);
        step(5'd0, 7'h00, "duck_mid", 1'b0, 1'b0, RES_JUEGO, 2'd1, AGACHADO);
        step(5'd0, 7'h00, "duck_hi",  1'b0, 1'b0, RES_JUEGO, 2'd1, AGACHADO);
        btn_agachar = 1'b0;
        idle("crouch_rel", 1'b0, 1'b0, RES_JUEGO, 2'd1, PIE);

        step(5'd5, 7'h7F, "pre_rst", 1'b0, 1'b0, RES_JUEGO, 2'd1, PIE);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle("rst_mid", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);
        step(5'd0, 7'h00, "rst_clr1", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);
        step(5'd0, 7'h00, "rst_clr2", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);
        step(5'd0, 7'h00, "rst_clr3", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);

        btn_salto   = 1'b1;
        btn_agachar = 1'b1;
        idle("both_btn", 1'b0, 1'b0, RES_JUEGO, 2'd3, SALTO);
        btn_salto = 1'b0;
        step(5'd0, 7'h00, "air_duck", 1'b0, 1'b0, RES_JUEGO, 2'd3, SALTO);
        step(5'd0, 7'h00, "air_land", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);
        btn_agachar = 1'b0;
        idle("land_idle", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);

        step(5'd5, 7'h7F, "ll_a",    1'b0, 1'b0, RES_JUEGO,  2'd3, PIE);
        step(5'd6, 7'h7F, "ll_b",    1'b0, 1'b0, RES_JUEGO,  2'd3, PIE);
        step(5'd5, 7'h7F, "ll_c",    1'b0, 1'b1, RES_JUEGO,  2'd2, PIE);
        step(5'd0, 7'h00, "ll_d",    1'b0, 1'b1, RES_JUEGO,  2'd1, PIE);
        step(5'd0, 7'h00, "ll_dead", 1'b0, 1'b0, RES_PIERDE, 2'd0, PIE);
        step(5'd16, 7'h7F, "dead_tick", 1'b0, 1'b0, RES_PIERDE, 2'd0, PIE);
        btn_salto = 1'b1;
        idle("dead_btn", 1'b0, 1'b0, RES_PIERDE, 2'd0, PIE);
        step(5'd5, 7'h7F, "dead_tick2", 1'b0, 1'b0, RES_PIERDE, 2'd0, PIE);

        presente = 3'd0;
        idle("off", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);
        step(5'd16, 7'h7F, "off_tick", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);
        btn_salto = 1'b1;
        idle("off_btn", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);
        btn_salto = 1'b0;
        presente  = 3'd3;

        mundo = 2'd0;
        step(5'd16, 7'h00, "bono0_in",  1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);
        step(5'd0,  7'h00, "bono0_mid", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);
        step(5'd0,  7'h00, "bono0_hit", 1'b1, 1'b0, RES_JUEGO, 2'd3, PIE);
        idle("bono0_end", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);

        mundo = 2'd2;
        step(5'd16, 7'h00, "bono2_in",  1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);
        step(5'd0,  7'h00, "bono2_mid", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);
        step(5'd0,  7'h00, "bono2_win", 1'b1, 1'b0, RES_GANA,  2'd3, PIE);
        idle("won_end", 1'b0, 1'b0, RES_GANA, 2'd3, PIE);

        presente = 3'd4;
        step(5'd5, 7'h7F, "wl_hold", 1'b0, 1'b0, RES_GANA, 2'd3, PIE);
        idle("wl_idle", 1'b0, 1'b0, RES_GANA, 2'd3, PIE);
        presente = 3'd0;
        idle("wl_off", 1'b0, 1'b0, RES_JUEGO, 2'd3, PIE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/detector_colisiones.md
Name: detector_colisiones

Overview:
- Consumer end of the obstacle stream produced by the obstacle generator.
- Reconstructs the per-slot obstacle types from `clk_obstaculos`, `tipo_obs` and `display_obs`, and runs the hero posture FSM from debounced buttons.
- Judges every obstacle arriving at the hero digit (slot 0) and drives `bono_tomado` and `W_or_L` back to the generator and the top-level game FSM.

Parameters:
- GAME, 3'd3, `presente` code for the playing state.
- WL, 3'd4, `presente` code for the win/lose screen.
- VIDAS, 3, lives at game start (1..3).
- SALTO_TICKS, 2, obstacle ticks a jump stays airborne (1..7).

Ports:
- clk  in  1  system clock, same domain as the generator.
- rst_n  in  1  synchronous active-low reset.
- presente  in  3  top-level FSM state.
- clk_obstaculos  in  1  registered obstacle-step clock from the generator, same clk domain.
- tipo_obs  in  5  obstacle type; 1..15 are LFSR types, 16 is the bonus.
- display_obs  in  21  segment stream; [20:14] is the entry slot, [6:0] is the hero slot.
- mundo  in  2  current world (0..2).
- btn_salto  in  1  jump button, debounced level.
- btn_agachar  in  1  crouch button, debounced level.
- bono_tomado  out  1  one-clk pulse when a bonus reaches slot 0.
- W_or_L  out  2  00 playing, 01 lost, 10 won.
- vidas  out  2  remaining lives.
- golpe  out  1  one-clk pulse on a non-fatal hit.
- postura  out  2  00 PIE, 01 SALTO, 10 AGACHADO.

Behaviour:
- **Reset** (rst_n=0 at posedge clk): all outputs and state clear.
  - bono_tomado=0, W_or_L=00, vidas=VIDAS, golpe=0, postura=PIE.
  - Type slots 2..0 = 0, jump counter = 0, tick edge register = 0.
- **Tick:** tick = clk_obstaculos & ~clk_obstaculos_q, where clk_obstaculos_q is a one-flop delay. It is a single-clk strobe, one clk after the generator's rising edge.
- **Type shadow pipeline**, three 5-bit slots, advances on tick only when presente==GAME and W_or_L==00:
  - slot0 <= slot1;
  - slot1 <= slot2;
  - slot2 <= (tipo_obs==16) ? 16 : (display_obs[20:14]!=0 ? tipo_obs : 0).
- **Judgement** on the same tick, using the new slot0 value and the posture registered before the tick:
  - tipo 16: pulse bono_tomado for 1 clk. If mundo==2, W_or_L <= 10 on the same clk.
  - tipo odd (low obstacle): hit unless postura==SALTO.
  - tipo even, nonzero (high obstacle): hit unless postura==AGACHADO.
  - Hit with vidas>1: vidas-1 and golpe pulses for 1 clk.
  - Hit with vidas==1: vidas<=0 and W_or_L <= 01. golpe does not pulse.
  - 0: no action.
- **Posture FSM**, evaluated every clk:
  - PIE:
    - btn_salto -> SALTO and load counter = SALTO_TICKS.
    - Otherwise btn_agachar -> AGACHADO.
    - If both buttons are pressed in the same clk, jump wins.
  - SALTO:
    - Decrement counter on each tick.
    - When the counter reaches 0 -> PIE.
    - Buttons are ignored while airborne.
  - AGACHADO: stays while btn_agachar=1; -> PIE the clk after release.
  - Posture changes on the same clk as a tick take effect from the next tick.
- **Frozen states:**
  - While W_or_L!=00: the pipeline, lives and posture are frozen.
  - While presente is not GAME/WL: the posture FSM is held at PIE.
- **Leaving GAME and WL:** when presente is neither GAME nor WL, the next clk applies the full reset values. This is also how a new game restarts.
- **Outside GAME:** no bono_tomado pulse and no hit is generated.
- **W_or_L:** held stable during WL. W_or_L=10 and 01 cannot both be requested on one tick, because slot0 holds a single type.

Decomposition:
- Shared package `heroe_pkg` holds:
  - presente codes OFF..PA;
  - W_or_L codes RES_JUEGO / RES_PIERDE / RES_GANA;
  - TIPO_BONO=16;
  - postura codes PIE / SALTO / AGACHADO.
- The generator switches to this package as well.
- One sub-module, `postura_heroe`: the posture FSM plus jump counter, with inputs tick, buttons and freeze, and output postura.

Test Plan:
1. **Reset:** hold rst_n=0 for 2 clk mid-game -> W_or_L=00, vidas=3, postura=00, slots 0, no pulses.
2. **Low obstacle, jump timed:** presente=GAME, inject tipo_obs=5 with segments !=0, and press btn_salto 1 clk before the 3rd tick -> at the 3rd tick slot0=5, no golpe, vidas=3. Repeat without the jump -> golpe pulses for 1 clk, vidas=2.
3. **High obstacle:** tipo_obs=6 arrives at slot0 while postura=PIE -> golpe. Same with btn_agachar held -> no hit.
4. **Last life:** vidas=1, unavoidable hit -> W_or_L=01 that clk. Further ticks change nothing. presente->OFF -> next clk W_or_L=00, vidas=3.
5. **Bonus / world:** tipo_obs=16 with mundo=0 -> bono_tomado pulses for exactly 1 clk 3 ticks later, W_or_L stays 00. With mundo=2 -> bono_tomado=1 and W_or_L=10 on the same clk.
6. **Posture edges:**
   - btn_salto and btn_agachar pressed together from PIE -> postura=01.
   - With SALTO_TICKS=2, postura returns to 00 exactly after the 2nd tick.
   - btn_agachar pressed during SALTO is ignored.
